// File: rtl/md_sequencer.sv
// md_sequencer: iterative RV32M multiply/divide unit for the EX stage.
// A single shared shift/add-subtract datapath produces one radix-2 step per
// cycle. EX is held through `stall` until the registered `result` is valid,
// which is signalled by a one-cycle `done` pulse.
//
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   start   - EX holds a valid M-extension instruction
//   funct3  - operation select (mul/mulh/mulhsu/mulhu/div/divu/rem/remu)
//   op_a    - rs1 value
//   op_b    - rs2 value
//   flush   - EX flush; aborts any operation in progress
//   stall   - hold IF/ID/EX registers
//   busy    - operation in progress (state is not IDLE)
//   done    - result valid this cycle (one-cycle pulse)
//   result  - registered result, held until the next acceptance
module md_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      func_q, func_d;
    logic [XLEN-1:0] hi_q, hi_d;     // product high word / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;     // multiplier-product low word / quotient
    logic [XLEN-1:0] opb_q, opb_d;   // multiplicand / divisor magnitude
    logic            neg_q, neg_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    // ---------------- operand decode (used on acceptance) ----------------
    logic            a_signed, b_signed, sa, sb, neg_in;
    logic            div_zero, sgn_ovf, special;
    logic [XLEN-1:0] a_mag, b_mag, special_res;
    logic [XLEN-1:0] int_min;

    assign int_min  = {1'b1, {(XLEN-1){1'b0}}};
    assign a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
    assign sa       = a_signed & op_a[XLEN-1];
    assign sb       = b_signed & op_b[XLEN-1];
    // Two's-complement negation of the most negative value yields the same
    // bit pattern, which read as unsigned is exactly its magnitude.
    assign a_mag    = sa ? (~op_a + 1'b1) : op_a;
    assign b_mag    = sb ? (~op_b + 1'b1) : op_b;
    // Remainder follows the dividend's sign; everything else is sa ^ sb.
    assign neg_in   = (funct3[2] & funct3[1]) ? sa : (sa ^ sb);

    assign div_zero = funct3[2] & (op_b == '0);
    assign sgn_ovf  = funct3[2] & ~funct3[0] & (op_a == int_min) & (op_b == '1);
    assign special  = div_zero | sgn_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = funct3[1] ? op_a : '1;
        end else if (sgn_ovf) begin
            special_res = funct3[1] ? '0 : int_min;
        end
    end

    // ---------------- shared radix-2 step ----------------
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] step_hi, step_lo;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        if (func_q[2]) begin
            // Restoring divide: trial subtract, keep it only if non-negative.
            step_hi = div_ge ? (div_shift[XLEN-1:0] - opb_q) : div_shift[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], div_ge};
        end else begin
            // Shift-add multiply: carry of the add shifts into the high word.
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // ---------------- sign fix-up / word select ----------------
    logic [2*XLEN-1:0] prod_neg;
    logic [XLEN-1:0]   fix_word;
    logic [XLEN-1:0]   sel_word;

    always_comb begin
        prod_neg = -{hi_q, lo_q};
        sel_word = '0;
        fix_word = '0;
        case (func_q)
            3'b000:                 fix_word = neg_q ? prod_neg[XLEN-1:0] : lo_q;
            3'b001, 3'b010, 3'b011: fix_word = neg_q ? prod_neg[2*XLEN-1:XLEN] : hi_q;
            default: begin
                sel_word = func_q[1] ? hi_q : lo_q;
                fix_word = neg_q ? (~sel_word + 1'b1) : sel_word;
            end
        endcase
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_d  = state_q;
        func_d   = func_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        stall    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    stall  = 1'b1;
                    func_d = funct3;
                    hi_d   = '0;
                    lo_d   = a_mag;
                    opb_d  = b_mag;
                    neg_d  = neg_in;
                    cnt_d  = '0;
                    if (special) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                stall = 1'b1;
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(XLEN-1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                stall    = 1'b1;
                result_d = fix_word;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything, and never disturbs the held result.
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            func_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            func_q   <= func_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Iterative multiply/divide sequencer for the RV32M instructions in the execute stage of the pipelined core. The ALU decoder flags M-extension R-type operations, and this block takes their operands, computes the result over multiple cycles with a shared shift/add-subtract datapath, and holds the pipeline through its stall output. Its result is muxed with the ALU result in EX when `done` is high. Only one operation is in flight at a time.

## Interface
- XLEN, 32, operand/result width (only 32 is supported)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  EX holds a valid M-extension instruction (opcode R-type, funct7 = 0000001)
- funct3  in  3  000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
- op_a  in  XLEN  rs1 value (forwarded)
- op_b  in  XLEN  rs2 value (forwarded)
- flush  in  1  EX flush (branch mispredict/redirect); aborts the operation
- stall  out  1  hold IF/ID/EX registers
- busy  out  1  an operation is in progress (state is not IDLE)
- done  out  1  result valid this cycle, one-cycle pulse
- result  out  XLEN  registered result; valid when done=1, holds its value until the next acceptance

## Operation
- Four states: IDLE, CALC, FIX, DONE.
- **IDLE:**
  - If start & ~flush: latch funct3, take the magnitudes of the operands (signedness per funct3), record the result sign, and clear the 6-bit counter.
  - If the op is a divide by zero or a signed overflow, go straight to DONE. Otherwise go to CALC.
- **CALC:** one radix-2 step per cycle; the counter increments each cycle. Exit to FIX when the counter reaches 31, which is 32 steps.
  - Multiply: 64-bit shift-add on the product register {hi, lo}, using unsigned magnitudes.
  - Divide: restoring step on {rem, quo}; subtract the divisor, keep the result if it is non-negative, shift in the quotient bit.
- **FIX:** apply the sign correction (two's complement when the recorded sign = 1), select the result word, and load `result`. Go to DONE.
  - mul selects the low word. mulh, mulhsu and mulhu select the high word.
  - div and divu select the quotient. rem and remu select the remainder.
  - The remainder takes the dividend's sign. The quotient sign is sign(a) XOR sign(b).
- **DONE:** done=1 for one cycle, then go to IDLE. start is ignored in DONE because the same instruction is still presenting it.
- **Special cases** (resolved in IDLE, loaded directly into `result`):
  - divisor = 0: div/divu → 0xFFFFFFFF; rem/remu → op_a.
  - div with op_a = 0x80000000 and op_b = 0xFFFFFFFF → 0x80000000; rem for the same operands → 0.
- **Signedness:**
  - mulh: both operands signed.
  - mulhsu: op_a signed, op_b unsigned.
  - mulhu, divu, remu: both unsigned.
  - The magnitude of 0x80000000 is 0x80000000, handled in 33-bit arithmetic.
- **flush:** in any state, flush=1 forces IDLE on the next edge. done does not assert and `result` is unchanged. In IDLE, flush masks start.
- start while busy: ignored; there is no queueing.

## Timing
- Reset values: state = IDLE, busy = 0, done = 0, stall = 0, result = 0, counter = 0.
- stall = (state==IDLE & start & ~flush) | (state==CALC) | (state==FIX).
  - stall is combinational, so EX holds from the acceptance cycle onward.
  - stall is low in DONE, so EX captures `result` and advances at the end of the DONE cycle.
- Normal latency: acceptance in cycle 0, CALC in cycles 1–32, FIX in cycle 33, done=1 in cycle 34. That is 34 stall cycles.
- Special-case latency: acceptance in cycle 0, done=1 in cycle 1. That is 1 stall cycle.
- Back-to-back ops: the next start can be accepted the cycle after DONE, when the state is IDLE again.
- Reset mid-operation: asynchronously returns to the reset values, with no done pulse.
- busy is registered: it is 1 in CALC, FIX and DONE.

## Test plan
- Reset: hold rst_n=0 mid-CALC → all outputs 0 immediately; after release, state is IDLE and stall=0.
- mul 7 × (−3) (op_b = 0xFFFFFFFD, funct3 000) → done in cycle 34, result = 0xFFFFFFEB. Then mulhu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. Then mulh 0x80000000 × 0x80000000 → 0x40000000.
- div −7 / 2 → 0xFFFFFFFD. rem −7 / 2 → 0xFFFFFFFF. divu 100 / 7 → 14. remu 100 / 7 → 2. Each has done in cycle 34 and stall high for exactly 34 cycles.
- div 5 / 0 → 0xFFFFFFFF with done in cycle 1. rem 5 / 0 → 5. div 0x80000000 / −1 → 0x80000000 with done in cycle 1. rem of the same operands → 0.
- flush at cycle 10 of CALC → IDLE next cycle, no done pulse, result keeps its previous value, stall drops. A new start 1 cycle later completes normally.
- start held through DONE → exactly one done pulse. A second op started the cycle after DONE completes 34 cycles later with the correct result.
